// File: rtl/spice_seq_pkg.sv
// Shared types, defaults and helpers for the SPICE chip-clock sequencer.
// Pure definitions; no timing or flow-control behaviour of its own.
package spice_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        IDLE  = 2'd1,
        PHASE = 2'd2,
        STEP  = 2'd3
    } seq_state_t;

    localparam int SEQ_SETTLE_DEFAULT = 32;
    localparam int SEQ_SETTLE_MIN     = 4;
    localparam int SEQ_RES_HALVES     = 12;
    localparam int SEQ_CNT_W          = 32;

    // A settle count below the latch qualifier window would let phi0 move before nodes settle.
    function automatic logic [7:0] clamp_settle(input logic [7:0] value, input logic [7:0] floor_value);
        return (value < floor_value) ? floor_value : value;
    endfunction

endpackage

// File: rtl/spice_phase_timer.sv
// Half-phase down-counter: loads load_value-1 on entry/boundary, strobes sample on the last cycle.
// Latency: load_value cycles per half-phase; no backpressure, stops only when enable drops.
module spice_phase_timer
    import spice_seq_pkg::*;
#(
    parameter logic [7:0] RESET_LOAD = 8'(SEQ_SETTLE_DEFAULT)
) (
    input  logic       eclk,
    input  logic       ereset_n,
    input  logic       enable,
    input  logic [7:0] load_value,
    output logic       sample,
    output logic       sample_nxt
);

    logic [7:0] cnt;
    logic       running;
    logic       reload;

    always_comb begin
        reload     = !running || sample;
        sample_nxt = enable && !reload && (cnt == 8'd1);
    end

    // Reset counts as entry into the first half-phase, so the counter comes up preloaded.
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            cnt     <= RESET_LOAD - 8'd1;
            running <= 1'b1;
            sample  <= 1'b0;
        end else begin
            running <= enable;
            sample  <= sample_nxt;
            if (enable) begin
                cnt <= reload ? (load_value - 8'd1) : (cnt - 8'd1);
            end
        end
    end

endmodule

// File: rtl/spice_clock_sequencer.sv
// Drives phi0/res_n for the netlist sim: reset hold, free-run, pause and single-step half-phases.
// Latency: settle_reg eclk per half-phase, registered outputs; host requests are never backpressured.
module spice_clock_sequencer
    import spice_seq_pkg::*;
#(
    parameter int SETTLE_DEFAULT = SEQ_SETTLE_DEFAULT,
    parameter int SETTLE_MIN     = SEQ_SETTLE_MIN,
    parameter int RES_HALVES     = SEQ_RES_HALVES,
    parameter int CNT_W          = SEQ_CNT_W
) (
    input  logic             eclk,
    input  logic             ereset_n,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    input  logic             chip_reset_req,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_settle,
    output logic             phi0,
    output logic             res_n,
    output logic             sample,
    output logic             busy,
    output logic [CNT_W-1:0] half_count
);

    localparam int RC_W = $clog2(RES_HALVES + 1);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [7:0]      settle_reg;
    logic [RC_W-1:0] res_cnt;
    logic            rst_pend;
    logic            reset_due;
    logic            hold_done;
    logic            tmr_enable;
    logic            sample_nxt;

    spice_phase_timer #(
        .RESET_LOAD (8'(SETTLE_DEFAULT))
    ) u_timer (
        .eclk       (eclk),
        .ereset_n   (ereset_n),
        .enable     (tmr_enable),
        .load_value (settle_reg),
        .sample     (sample),
        .sample_nxt (sample_nxt)
    );

    always_comb begin
        state_nxt = state;
        reset_due = rst_pend || chip_reset_req;
        hold_done = (res_cnt == RC_W'(RES_HALVES - 1));
        case (state)
            HOLD: begin
                if (sample && !reset_due && hold_done) begin
                    state_nxt = run ? PHASE : IDLE;
                end
            end
            IDLE: begin
                if (chip_reset_req)  state_nxt = HOLD;
                else if (run)        state_nxt = PHASE;
                else if (step_req)   state_nxt = STEP;
            end
            PHASE: begin
                if (sample) begin
                    if (reset_due)   state_nxt = HOLD;
                    else if (!run)   state_nxt = IDLE;
                end
            end
            STEP: begin
                if (sample) state_nxt = reset_due ? HOLD : IDLE;
            end
            default: state_nxt = HOLD;
        endcase
        tmr_enable = (state_nxt != IDLE);
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state      <= HOLD;
            settle_reg <= 8'(SETTLE_DEFAULT);
            res_cnt    <= '0;
            rst_pend   <= 1'b0;
            phi0       <= 1'b0;
            res_n      <= 1'b0;
            step_ack   <= 1'b0;
            busy       <= 1'b0;
            half_count <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == PHASE) || (state_nxt == STEP);
            step_ack <= (state_nxt == STEP) && sample_nxt;
            if (cfg_we) begin
                settle_reg <= clamp_settle(cfg_settle, 8'(SETTLE_MIN));
            end
            if (state == IDLE) begin
                if (chip_reset_req) begin
                    res_n   <= 1'b0;
                    res_cnt <= '0;
                end
            end else if (sample) begin
                // Half-phase boundary: a pending reset request is honoured only here.
                phi0     <= ~phi0;
                rst_pend <= 1'b0;
                if (reset_due) begin
                    res_n      <= 1'b0;
                    res_cnt    <= '0;
                    half_count <= half_count + CNT_W'(1);
                end else if (state == HOLD && hold_done) begin
                    res_n      <= 1'b1;
                    res_cnt    <= '0;
                    half_count <= '0;
                end else begin
                    half_count <= half_count + CNT_W'(1);
                    if (state == HOLD) res_cnt <= res_cnt + RC_W'(1);
                end
            end else if (chip_reset_req) begin
                rst_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spice_clock_sequencer.sv
// Scoreboard bench: the driver predicts the cycle and pin values of every sample strobe,
// a negedge monitor pops and compares each strobe the DUT produces.
module tb_spice_clock_sequencer;

    localparam int S_DEF = 32;
    localparam int S_MIN = 4;
    localparam int R_H   = 12;

    logic        eclk = 1'b0;
    logic        ereset_n = 1'b0;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic        chip_reset_req = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_settle = 8'd0;
    logic        step_ack;
    logic        phi0;
    logic        res_n;
    logic        sample;
    logic        busy;
    logic [31:0] half_count;

    spice_clock_sequencer dut (
        .eclk           (eclk),
        .ereset_n       (ereset_n),
        .run            (run),
        .step_req       (step_req),
        .step_ack       (step_ack),
        .chip_reset_req (chip_reset_req),
        .cfg_we         (cfg_we),
        .cfg_settle     (cfg_settle),
        .phi0           (phi0),
        .res_n          (res_n),
        .sample         (sample),
        .busy           (busy),
        .half_count     (half_count)
    );

    always #5 eclk = ~eclk;

    int cyc = 0;
    always @(posedge eclk) cyc <= cyc + 1;

    typedef struct {
        int   t;
        logic phi0;
        logic res_n;
        logic busy;
        logic ack;
        int   hc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state: pin values and settle count as seen by the next half-phase.
    logic m_phi0;
    logic m_res_n;
    int   m_hc;
    int   m_settle;
    int   m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    always @(negedge eclk) begin
        if (ereset_n === 1'b1) begin
            if (sample === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample at cycle %0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sample_cycle", cyc, mon_e.t);
                    chk("phi0_at_sample", phi0, mon_e.phi0);
                    chk("res_n_at_sample", res_n, mon_e.res_n);
                    chk("busy_at_sample", busy, mon_e.busy);
                    chk("step_ack_at_sample", step_ack, mon_e.ack);
                    chk("half_count_at_sample", half_count, mon_e.hc);
                end
            end
            if (step_ack === 1'b1 && sample !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL step_ack_without_sample at cycle %0d", cyc);
            end
        end
    end

    task automatic push_half(input int t, input logic busy_e, input logic ack_e);
        exp_q.push_back('{t: t, phi0: m_phi0, res_n: m_res_n, busy: busy_e, ack: ack_e, hc: m_hc});
        m_phi0 = ~m_phi0;
        m_hc   = m_hc + 1;
        m_last = t;
    endtask

    task automatic hold_seq(input int t0);
        m_res_n = 1'b0;
        for (int i = 0; i < R_H; i++) push_half(t0 + i * m_settle, 1'b0, 1'b0);
        m_res_n = 1'b1;
        m_hc    = 0;
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while (guard < 20000 && (exp_q.size() != 0 || cyc <= m_last + 1)) begin
            @(negedge eclk);
            guard++;
        end
        if (guard >= 20000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d expected samples never seen", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_phi0"}, phi0, m_phi0);
        chk({tag, "_res_n"}, res_n, m_res_n);
        chk({tag, "_half_count"}, half_count, m_hc);
        chk({tag, "_sample"}, sample, 0);
    endtask

    task automatic release_reset();
        ereset_n = 1'b1;
        m_phi0   = 1'b0;
        m_res_n  = 1'b0;
        m_hc     = 0;
        m_settle = S_DEF;
        // The released cycle is the first cycle of the first hold half-phase.
        hold_seq(cyc + S_DEF - 1);
        wait_drain("reset_hold");
    endtask

    task automatic cfg_pulse(input int v);
        cfg_we     = 1'b1;
        cfg_settle = 8'(v);
        @(negedge eclk);
        cfg_we   = 1'b0;
        m_settle = (v < S_MIN) ? S_MIN : v;
    endtask

    // Free-run n half-phases, optionally writing the settle count wr_off cycles after start.
    task automatic run_seq(input int n, input int wr_off, input int wr_val, input bit with_step);
        int c, st, len, t_prev, t_pen, drop, latch_e, newv, old_s, last_cy;
        c       = cyc;
        old_s   = m_settle;
        newv    = (wr_off >= 0) ? ((wr_val < S_MIN) ? S_MIN : wr_val) : old_s;
        latch_e = c + wr_off + 1;
        t_prev  = c;
        t_pen   = c;
        for (int k = 0; k < n; k++) begin
            st     = t_prev + 1;
            len    = (wr_off >= 0 && latch_e < st) ? newv : old_s;
            t_pen  = t_prev;
            t_prev = st + len - 1;
            push_half(t_prev, 1'b1, 1'b0);
        end
        m_settle = newv;
        drop     = int'($urandom_range(t_prev, t_pen + 1));
        last_cy  = (wr_off >= 0 && c + wr_off > drop) ? c + wr_off : drop;
        for (int cy = c; cy <= last_cy + 1; cy++) begin
            if (cy != c) @(negedge eclk);
            run        = (cy < drop);
            step_req   = with_step && (cy == c);
            cfg_we     = (wr_off >= 0) && (cy == c + wr_off);
            cfg_settle = 8'(wr_val);
        end
        wait_drain("run");
    endtask

    task automatic step_once(input bit extra);
        int c, k;
        c = cyc;
        push_half(c + m_settle, 1'b1, 1'b1);
        step_req = 1'b1;
        @(negedge eclk);
        step_req = 1'b0;
        if (extra) begin
            k = int'($urandom_range(m_settle - 2, 0));
            repeat (k) @(negedge eclk);
            chk("busy_in_step", busy, 1);
            step_req = 1'b1;
            @(negedge eclk);
            step_req = 1'b0;
        end
        wait_drain("step");
    endtask

    task automatic reset_req_in_idle();
        int c;
        c = cyc;
        chip_reset_req = 1'b1;
        hold_seq(c + m_settle);
        @(negedge eclk);
        chip_reset_req = 1'b0;
        chk("res_n_enter_hold", res_n, 0);
        wait_drain("idle_reset");
    endtask

    task automatic reset_req_in_phase();
        int c, t2;
        c    = cyc;
        run  = 1'b1;
        push_half(c + m_settle, 1'b1, 1'b0);
        t2   = c + 2 * m_settle;
        push_half(t2, 1'b1, 1'b0);
        repeat (t2 - 10 - c) @(negedge eclk);
        chip_reset_req = 1'b1;
        run            = 1'b0;
        @(negedge eclk);
        chip_reset_req = 1'b0;
        chk("res_n_pending", res_n, 1);
        chk("busy_pending", busy, 1);
        hold_seq(t2 + m_settle);
        wait_drain("phase_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, wo;
        repeat (3) @(negedge eclk);
        chk("rst_phi0", phi0, 0);
        chk("rst_res_n", res_n, 0);
        chk("rst_sample", sample, 0);
        chk("rst_step_ack", step_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_half_count", half_count, 0);
        release_reset();
        idle_check("after_reset");

        run_seq(100, -1, 0, 1'b0);
        idle_check("after_run100");

        for (int i = 0; i < 3; i++) step_once(1'b1);
        idle_check("after_steps");

        run_seq(6, 5, 2, 1'b0);
        run_seq(3, 0, 200, 1'b0);
        cfg_pulse(S_DEF);
        idle_check("after_cfg");

        reset_req_in_phase();
        idle_check("after_phase_reset");

        cfg_pulse(6);
        for (int i = 0; i < 16; i++) begin
            op = int'($urandom_range(3, 0));
            case (op)
                0: step_once(1'($urandom_range(1, 0)));
                1: begin
                    wo = ($urandom_range(1, 0) == 1) ? int'($urandom_range(m_settle + 2, 0)) : -1;
                    run_seq(int'($urandom_range(4, 1)), wo, int'($urandom_range(12, 0)), 1'b0);
                end
                2: reset_req_in_idle();
                default: run_seq(int'($urandom_range(3, 1)), -1, 0, 1'b1);
            endcase
            idle_check("random_op");
        end

        cfg_pulse(20);
        step_req = 1'b1;
        @(negedge eclk);
        step_req = 1'b0;
        repeat (9) @(negedge eclk);
        ereset_n = 1'b0;
        #1;
        chk("midstep_rst_phi0", phi0, 0);
        chk("midstep_rst_res_n", res_n, 0);
        chk("midstep_rst_busy", busy, 0);
        chk("midstep_rst_step_ack", step_ack, 0);
        chk("midstep_rst_sample", sample, 0);
        chk("midstep_rst_half_count", half_count, 0);
        repeat (3) @(negedge eclk);
        release_reset();
        idle_check("after_midstep_reset");

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
